// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding
// for the fetch-stage PC generator.
package pc_pkg;

  localparam int          XLEN_D         = 32;
  localparam logic [31:0] RESET_VECTOR_D = 32'h0000_0000;
  localparam int          ALIGN_D        = 2;
  localparam int          RAS_DEPTH_D    = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_RAS,
    SRC_REDIRECT,
    SRC_TRAP,
    SRC_HOLD
  } pc_src_e;

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating
// count; a full push overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            empty;
  logic            full;
  logic            both;
  logic            push_only;
  logic            pop_only;
  logic [PW-1:0]   waddr;

  always_comb begin
    empty     = (cnt == '0);
    full      = (cnt == CW'(DEPTH));
    both      = push & pop & ~empty;
    push_only = push & ~both;
    pop_only  = pop & ~push & ~empty;
    waddr     = both ? ptr : ptr + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (push_only) begin
        ptr <= ptr + PW'(1);
        if (!full) cnt <= cnt + CW'(1);
      end else if (pop_only) begin
        ptr <= ptr - PW'(1);
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Entry contents need no reset; count gates their use.
  always_ff @(posedge clk) begin
    if (push) mem[waddr] <= data;
  end

  assign top   = mem[ptr];
  assign count = cnt;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority next-PC
// mux, alignment forcing and RAS prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_D,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_D),
  parameter int              RAS_DEPTH    = RAS_DEPTH_D,
  parameter int              ALIGN        = ALIGN_D
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           PC_EN,
  input  logic                           TRAP_VALID,
  input  logic [XLEN-1:0]                TRAP_VEC,
  input  logic                           REDIRECT_VALID,
  input  logic [XLEN-1:0]                REDIRECT_PC,
  input  logic                           RAS_PUSH,
  input  logic                           RAS_POP,
  output logic [XLEN-1:0]                PC_OUT,
  output logic [XLEN-1:0]                PC_PLUS4,
  output logic                           MISALIGNED,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RAS_COUNT
);

  localparam logic [XLEN-1:0] LOW_MASK =
    (XLEN'(1) << ALIGN) - XLEN'(1);

  logic [XLEN-1:0] pc_q;
  logic            mis_q;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  pc_src_e         src;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] pc_d;
  logic            mis_d;

  assign PC_PLUS4 = pc_q + XLEN'(4);

  // Traps drop RAS ops; stalls freeze the stack.
  assign ras_push = RAS_PUSH & PC_EN & ~TRAP_VALID;
  assign ras_pop  = RAS_POP & PC_EN & ~TRAP_VALID;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (ras_push),
    .pop   (ras_pop),
    .data  (PC_PLUS4),
    .top   (ras_top),
    .count (RAS_COUNT)
  );

  always_comb begin
    src = SRC_SEQ;
    if (TRAP_VALID)
      src = SRC_TRAP;
    else if (REDIRECT_VALID)
      src = SRC_REDIRECT;
    else if (!PC_EN)
      src = SRC_HOLD;
    else if (RAS_POP && RAS_COUNT != '0)
      src = SRC_RAS;
  end

  always_comb begin
    raw   = PC_PLUS4;
    mis_d = 1'b0;
    pc_d  = pc_q;
    unique case (src)
      SRC_TRAP:     raw = TRAP_VEC;
      SRC_REDIRECT: raw = REDIRECT_PC;
      SRC_RAS:      raw = ras_top;
      default:      raw = PC_PLUS4;
    endcase
    if (src == SRC_TRAP || src == SRC_REDIRECT)
      mis_d = |(raw & LOW_MASK);
    if (src != SRC_HOLD)
      pc_d = raw & ~LOW_MASK;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign PC_OUT     = pc_q;
  assign MISALIGNED = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit with a
// non-zero reset vector and RAS depth 4.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        trap_v;
  logic [31:0] trap_vec;
  logic        rd_v;
  logic [31:0] rd_pc;
  logic        push;
  logic        pop;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        mis;
  logic [2:0]  cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        mis;
    logic [2:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_1000),
    .RAS_DEPTH    (4),
    .ALIGN        (2)
  ) dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .PC_EN          (en),
    .TRAP_VALID     (trap_v),
    .TRAP_VEC       (trap_vec),
    .REDIRECT_VALID (rd_v),
    .REDIRECT_PC    (rd_pc),
    .RAS_PUSH       (push),
    .RAS_POP        (pop),
    .PC_OUT         (pc),
    .PC_PLUS4       (pc4),
    .MISALIGNED     (mis),
    .RAS_COUNT      (cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, obs, exp);
  endtask

  task automatic step(input string tag,
                      input logic e, tv,
                      input logic [31:0] tvec,
                      input logic rv,
                      input logic [31:0] rpc,
                      input logic pu, po,
                      input logic [31:0] epc,
                      input logic emis,
                      input logic [2:0] ecnt);
    exp_t x;
    @(negedge clk);
    en       = e;
    trap_v   = tv;
    trap_vec = tvec;
    rd_v     = rv;
    rd_pc    = rpc;
    push     = pu;
    pop      = po;
    x.tag = tag;
    x.pc  = epc;
    x.mis = emis;
    x.cnt = ecnt;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      cur = q.pop_front();
      chk({cur.tag, ".pc"}, pc, cur.pc);
      chk({cur.tag, ".pc4"}, pc4, cur.pc + 32'd4);
      chk({cur.tag, ".mis"}, 32'(mis), 32'(cur.mis));
      chk({cur.tag, ".cnt"}, 32'(cnt), 32'(cur.cnt));
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, ".pc"}, pc, 32'h0000_1000);
    chk({tag, ".mis"}, 32'(mis), 32'd0);
    chk({tag, ".cnt"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    trap_v   = 1'b0;
    trap_vec = '0;
    rd_v     = 1'b0;
    rd_pc    = '0;
    push     = 1'b0;
    pop      = 1'b0;
    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    step("seq0", 1,0,0, 0,0, 0,0, 32'h1004, 0, 0);
    step("seq1", 1,0,0, 0,0, 0,0, 32'h1008, 0, 0);
    step("seq2", 1,0,0, 0,0, 0,0, 32'h100C, 0, 0);
    step("prio", 0,1,32'h200, 1,32'hDEADBEEC, 0,0,
         32'h200, 0, 0);
    step("redir", 0,0,0, 1,32'hDEADBEEC, 0,0,
         32'hDEADBEEC, 0, 0);
    step("misal", 0,0,0, 1,32'hDEADBEEF, 0,0,
         32'hDEADBEEC, 1, 0);
    step("stall1", 0,0,0, 0,0, 0,0, 32'hDEADBEEC, 0, 0);
    step("stall2", 0,0,0, 0,0, 0,0, 32'hDEADBEEC, 0, 0);
    step("to100", 0,0,0, 1,32'h100, 0,0, 32'h100, 0, 0);
    step("call1", 1,0,0, 0,0, 1,0, 32'h104, 0, 1);
    step("call2", 1,0,0, 0,0, 1,0, 32'h108, 0, 2);
    step("stpop", 0,0,0, 0,0, 0,1, 32'h108, 0, 2);
    step("ret1", 1,0,0, 0,0, 0,1, 32'h108, 0, 1);
    step("ret2", 1,0,0, 0,0, 0,1, 32'h104, 0, 0);
    step("ret3", 1,0,0, 0,0, 0,1, 32'h108, 0, 0);

    step("to0", 0,0,0, 1,32'h0, 0,0, 32'h0, 0, 0);
    step("ovf1", 1,0,0, 0,0, 1,0, 32'h4, 0, 1);
    step("ovf2", 1,0,0, 0,0, 1,0, 32'h8, 0, 2);
    step("ovf3", 1,0,0, 0,0, 1,0, 32'hC, 0, 3);
    step("ovf4", 1,0,0, 0,0, 1,0, 32'h10, 0, 4);
    step("ovf5", 1,0,0, 0,0, 1,0, 32'h14, 0, 4);
    step("opop1", 1,0,0, 0,0, 0,1, 32'h14, 0, 3);
    step("opop2", 1,0,0, 0,0, 0,1, 32'h10, 0, 2);
    step("opop3", 1,0,0, 0,0, 0,1, 32'hC, 0, 1);
    step("opop4", 1,0,0, 0,0, 0,1, 32'h8, 0, 0);

    step("tomax", 0,0,0, 1,32'hFFFF_FFFC, 0,0,
         32'hFFFF_FFFC, 0, 0);
    step("wrap", 1,0,0, 0,0, 0,0, 32'h0, 0, 0);
    step("to3c", 0,0,0, 1,32'h3C, 0,0, 32'h3C, 0, 0);
    step("push40", 1,0,0, 0,0, 1,0, 32'h40, 0, 1);
    step("to80", 0,0,0, 1,32'h80, 0,0, 32'h80, 0, 1);
    step("pushpop", 1,0,0, 0,0, 1,1, 32'h40, 0, 1);
    step("pop84", 1,0,0, 0,0, 0,1, 32'h84, 0, 0);

    step("trapras", 1,1,32'h203, 0,0, 1,0, 32'h200, 1, 0);
    step("rdpush", 1,0,0, 1,32'h500, 1,0, 32'h500, 0, 1);
    step("pop204", 1,0,0, 0,0, 0,1, 32'h204, 0, 0);
    step("rdstall", 0,0,0, 1,32'h600, 1,0, 32'h600, 0, 0);
    step("emptypp", 1,0,0, 0,0, 1,1, 32'h604, 0, 1);
    step("push2", 1,0,0, 0,0, 1,0, 32'h608, 0, 2);

    @(negedge clk);
    en   = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post0", 1,0,0, 0,0, 0,0, 32'h1004, 0, 0);
    step("post1", 1,0,0, 0,0, 0,1, 32'h1008, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge clk);
    #3;
    if (q.size() != 0)
      chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
